// File: rtl/mem_wbuf.sv
`default_nettype none
// ============================================================================
// mem_wbuf : posted-store write buffer retiring stores as Wishbone classic
//            writes; MEM_WBUF_FWD_EN enables load forwarding of full words.
// rev 1.0
// ============================================================================
module mem_wbuf #(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] address_i,
  input  logic [31:0] data_i,
  input  logic [3:0]  sel_i,
  input  logic        we_i,
  output logic        stall_o,
  output logic        empty_o,
  input  logic [31:0] rd_address_i,
  output logic        fwd_hit_o,
  output logic [31:0] fwd_data_o,
  output logic        fwd_conflict_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        err_o
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUS  = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [29:0]   addr_mem [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [3:0]    sel_mem  [DEPTH];
  logic [AW-1:0] head, tail, idx;
  logic [AW:0]   count;
  logic          push, pop, start;
  logic          match;
  logic          unused_ok;

  assign push    = we_i & (count != FULL);
  assign stall_o = we_i & (count == FULL);
  assign pop     = (state == BUS) & (wb_ack_i | wb_err_i);
  assign empty_o = (count == '0) & (state == IDLE);

  assign unused_ok = ^{address_i[1:0], rd_address_i[1:0]};

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      IDLE: if (count != '0) begin
        state_nxt = BUS;
        start     = 1'b1;
      end
      BUS: if (wb_ack_i | wb_err_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_mem[tail] <= address_i[31:2];
      data_mem[tail] <= data_i;
      sel_mem[tail]  <= sel_i;
    end
  end

  // Bus outputs are registered; address/data/sel simply hold after the cycle ends.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_sel_o <= '0;
      wb_we_o  <= 1'b0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      err_o <= pop & wb_err_i;
      if (start) begin
        wb_adr_o <= {addr_mem[head], 2'b00};
        wb_dat_o <= data_mem[head];
        wb_sel_o <= sel_mem[head];
        wb_we_o  <= 1'b1;
        wb_cyc_o <= 1'b1;
        wb_stb_o <= 1'b1;
      end else if (pop) begin
        wb_we_o  <= 1'b0;
        wb_cyc_o <= 1'b0;
        wb_stb_o <= 1'b0;
      end
    end
  end

`ifdef MEM_WBUF_FWD_EN
  logic        match_full;
  logic [31:0] match_data;

  // Scan oldest to youngest so the last hit (nearest the tail) wins.
  always_comb begin
    match      = 1'b0;
    match_full = 1'b0;
    match_data = '0;
    idx        = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + AW'(i);
      if (((AW+1)'(i) < count) && (addr_mem[idx] == rd_address_i[31:2])) begin
        match      = 1'b1;
        match_full = (sel_mem[idx] == 4'hF);
        match_data = data_mem[idx];
      end
    end
  end

  assign fwd_hit_o      = match & match_full;
  assign fwd_data_o     = fwd_hit_o ? match_data : '0;
  assign fwd_conflict_o = match & ~match_full;
`else
  always_comb begin
    match = 1'b0;
    idx   = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + AW'(i);
      if (((AW+1)'(i) < count) && (addr_mem[idx] == rd_address_i[31:2]))
        match = 1'b1;
    end
  end

  assign fwd_hit_o      = 1'b0;
  assign fwd_data_o     = '0;
  assign fwd_conflict_o = match;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_wbuf.sv
`default_nettype none
// ============================================================================
// tb_mem_wbuf : directed plus randomized bench with a queue-based store model.
// rev 1.0
// ============================================================================
module tb_mem_wbuf;

  localparam int DEPTH = 4;
`ifdef MEM_WBUF_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk;
  logic        rst_i;
  logic [31:0] address_i, data_i, rd_address_i;
  logic [3:0]  sel_i;
  logic        we_i, wb_ack_i, wb_err_i;
  logic        stall_o, empty_o, fwd_hit_o, fwd_conflict_o;
  logic [31:0] fwd_data_o, wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o, err_o;

  mem_wbuf #(.DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .address_i(address_i), .data_i(data_i), .sel_i(sel_i), .we_i(we_i),
    .stall_o(stall_o), .empty_o(empty_o),
    .rd_address_i(rd_address_i), .fwd_hit_o(fwd_hit_o),
    .fwd_data_o(fwd_data_o), .fwd_conflict_o(fwd_conflict_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: queue of accepted stores in order; the front one is on the bus when busy.
  typedef struct packed {
    logic [29:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } ent_t;

  ent_t q[$];
  bit   busy     = 1'b0;
  bit   exp_err  = 1'b0;
  bit   model_ok = 1'b0;

  function automatic void exp_fwd(input logic [31:0] ra, output bit hit,
                                  output logic [31:0] d, output bit conf);
    hit  = 1'b0;
    d    = '0;
    conf = 1'b0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].a == ra[31:2]) begin
        if (FWD && q[i].s == 4'hF) begin
          hit = 1'b1;
          d   = q[i].d;
        end else begin
          conf = 1'b1;
        end
        break;
      end
    end
  endfunction

  // Compare at the falling edge, then advance the model across the coming rising edge.
  always @(negedge clk) begin
    bit          eh, ec, pop, push, start;
    logic [31:0] ed;
    if (model_ok) begin
      exp_fwd(rd_address_i, eh, ed, ec);
      chk1("stall", stall_o, we_i && (q.size() == DEPTH));
      chk1("empty", empty_o, (q.size() == 0) && !busy);
      chk1("cyc", wb_cyc_o, busy);
      chk1("stb", wb_stb_o, busy);
      chk1("we", wb_we_o, busy);
      chk1("err", err_o, exp_err);
      chk1("fwd_hit", fwd_hit_o, eh);
      chk1("fwd_conflict", fwd_conflict_o, ec);
      if (eh || !FWD) chk32("fwd_data", fwd_data_o, ed);
      if (busy) begin
        chk32("adr", wb_adr_o, {q[0].a, 2'b00});
        chk32("dat", wb_dat_o, q[0].d);
        chk32("sel", {28'd0, wb_sel_o}, {28'd0, q[0].s});
      end
    end
    if (rst_i) begin
      q.delete();
      busy     = 1'b0;
      exp_err  = 1'b0;
      model_ok = 1'b1;
    end else begin
      pop     = busy && (wb_ack_i || wb_err_i);
      push    = we_i && (q.size() < DEPTH);
      start   = !busy && (q.size() != 0);
      exp_err = pop && wb_err_i;
      if (pop) begin
        void'(q.pop_front());
        busy = 1'b0;
      end
      if (start) busy = 1'b1;
      if (push) q.push_back('{address_i[31:2], data_i, sel_i});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    we_i = 1'b1; address_i = a; data_i = d; sel_i = s;
    step();
    we_i = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    for (int n = 0; n < 60 && !empty_o; n++) step();
    chk1(name, empty_o, 1'b1);
  endtask

  initial begin
    rst_i = 1'b1; we_i = 1'b0; address_i = '0; data_i = '0; sel_i = '0;
    rd_address_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
    repeat (3) step();
    chk1("rst_empty", empty_o, 1'b1);
    chk1("rst_cyc", wb_cyc_o, 1'b0);
    chk32("rst_adr", wb_adr_o, 32'h0);
    chk1("rst_err", err_o, 1'b0);
    chk1("rst_stall", stall_o, 1'b0);
    rst_i = 1'b0;

    // single store, zero-wait ack
    wb_ack_i = 1'b1;
    store(32'h0000_0104, 32'hDEAD_BEEF, 4'hF);
    step();
    chk1("single_stb", wb_stb_o, 1'b1);
    chk32("single_adr", wb_adr_o, 32'h0000_0104);
    chk32("single_dat", wb_dat_o, 32'hDEAD_BEEF);
    step();
    chk1("single_empty", empty_o, 1'b1);

    // fill with bus stalled
    wb_ack_i = 1'b0;
    for (int k = 0; k < DEPTH; k++) store(32'h1000 + 32'(4 * k), $urandom, 4'hF);
    we_i = 1'b1; address_i = 32'h1010; data_i = 32'h5555_AAAA; sel_i = 4'hF;
    #1;
    chk1("full_stall", stall_o, 1'b1);
    chk32("fill_head_adr", wb_adr_o, 32'h1000);
    wb_ack_i = 1'b1;
    for (int n = 0; n < 10 && stall_o; n++) step();
    chk1("stall_release", stall_o, 1'b0);
    step();
    we_i = 1'b0;
    wait_empty("fill_drain");

    // forwarding
    wb_ack_i = 1'b0;
    store(32'h200, 32'h1111_1111, 4'hF);
    store(32'h200, 32'h2222_2222, 4'hF);
    rd_address_i = 32'h202;
    #1;
`ifdef MEM_WBUF_FWD_EN
    chk1("fwd_full_hit", fwd_hit_o, 1'b1);
    chk32("fwd_full_data", fwd_data_o, 32'h2222_2222);
    chk1("fwd_full_conf", fwd_conflict_o, 1'b0);
`else
    chk1("fwd_full_hit", fwd_hit_o, 1'b0);
    chk1("fwd_full_conf", fwd_conflict_o, 1'b1);
`endif
    store(32'h200, 32'h3333_3333, 4'h1);
    #1;
    chk1("fwd_part_hit", fwd_hit_o, 1'b0);
    chk1("fwd_part_conf", fwd_conflict_o, 1'b1);
    rd_address_i = 32'h300;
    #1;
    chk1("fwd_miss_conf", fwd_conflict_o, 1'b0);
    rd_address_i = '0;
    wb_ack_i = 1'b1;
    wait_empty("fwd_drain");

    // bus error on first of two stores
    wb_ack_i = 1'b0;
    store(32'h400, 32'hAAAA_0001, 4'hF);
    store(32'h404, 32'hAAAA_0002, 4'hF);
    chk1("err_pre_stb", wb_stb_o, 1'b1);
    wb_err_i = 1'b1;
    step();
    wb_err_i = 1'b0;
    wb_ack_i = 1'b1;
    chk1("err_pulse", err_o, 1'b1);
    step();
    chk1("err_once", err_o, 1'b0);
    wait_empty("err_drain");

    // reset mid-cycle
    wb_ack_i = 1'b0;
    store(32'h500, 32'h1, 4'hF);
    store(32'h504, 32'h2, 4'hF);
    store(32'h508, 32'h3, 4'hF);
    chk1("mid_pre_stb", wb_stb_o, 1'b1);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk1("mid_cyc", wb_cyc_o, 1'b0);
    chk1("mid_empty", empty_o, 1'b1);
    wb_ack_i = 1'b1;
    step();
    wb_ack_i = 1'b0;
    chk1("late_ack_err", err_o, 1'b0);
    chk1("late_ack_empty", empty_o, 1'b1);

    // randomized traffic with small address sets to provoke matches
    for (int i = 0; i < 3000; i++) begin
      we_i         = 1'($urandom_range(0, 1));
      address_i    = 32'h800 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
      data_i       = $urandom;
      sel_i        = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
      rd_address_i = 32'h800 + 32'($urandom_range(0, 8) * 4) + 32'($urandom_range(0, 3));
      wb_ack_i     = 1'($urandom_range(0, 1));
      wb_err_i     = ($urandom_range(0, 9) == 0);
      rst_i        = ($urandom_range(0, 299) == 0);
      step();
    end
    rst_i = 1'b0; we_i = 1'b0; wb_err_i = 1'b0; wb_ack_i = 1'b1;
    wait_empty("final_drain");
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
